// File: rtl/argmax_stream_ctrl.sv
// Serial argmax over one frame of N_CLASS sign-magnitude scores, one comparator, one beat per score handshake.
// Result valid 1 cycle after the last beat; producer may stall indefinitely, result holds until accepted.
module argmax_stream_ctrl #(
  parameter int BIT     = 16,
  parameter int N_CLASS = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           score_valid,
  input  logic [BIT-1:0] score_data,
  output logic           score_ready,
  output logic           result_valid,
  input  logic           result_ready,
  output logic [3:0]     result_index,
  output logic [BIT-1:0] result_max,
  output logic           sat_seen,
  output logic           busy
);

  localparam logic [BIT-1:0] SENT = {1'b1, {(BIT-1){1'b0}}};
  localparam logic [3:0]     LAST = 4'(N_CLASS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic [BIT-1:0] r_max;
  logic [3:0]     r_idx;
  logic           r_sat;
  logic [BIT-1:0] r_res_max;
  logic [3:0]     r_res_idx;
  logic           r_res_sat;

  logic           w_beat;
  logic           w_last;
  logic           w_clear;
  logic           w_take;
  logic [3:0]     w_digit;
  logic [BIT-1:0] w_upd_max;
  logic [3:0]     w_upd_idx;
  logic           w_upd_sat;

  // Sentinel is sticky: once held nothing displaces it; ties keep the incumbent.
  function automatic logic f_better(input logic [BIT-1:0] cur, input logic [BIT-1:0] nw);
    logic res;
    res = 1'b0;
    if (cur == SENT)
      res = 1'b0;
    else if (nw == SENT)
      res = 1'b1;
    else if (!nw[BIT-1] && cur[BIT-1])
      res = 1'b1;
    else if (nw[BIT-1] == cur[BIT-1])
      res = nw[BIT-1] ? (nw[BIT-2:0] < cur[BIT-2:0]) : (nw[BIT-2:0] > cur[BIT-2:0]);
    return res;
  endfunction

  assign w_beat    = score_valid && (r_state == S_COLLECT);
  assign w_last    = w_beat && (r_cnt == LAST);
  assign w_clear   = (r_state == S_IDLE && start) ||
                     (r_state == S_DONE && !abort && result_ready && start);
  assign w_digit   = LAST - r_cnt;
  assign w_take    = (r_cnt == 4'd0) || f_better(r_max, score_data);
  assign w_upd_max = w_take ? score_data : r_max;
  assign w_upd_idx = w_take ? w_digit : r_idx;
  assign w_upd_sat = r_sat || (score_data == SENT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COLLECT;
      S_COLLECT: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (abort)             w_next = S_IDLE;
        else if (result_ready) w_next = start ? S_COLLECT : S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    score_ready  = (r_state == S_COLLECT);
    result_valid = (r_state == S_DONE);
    busy         = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_sat     <= 1'b0;
      r_res_max <= '0;
      r_res_idx <= '0;
      r_res_sat <= 1'b0;
    end else begin
      if (w_clear) begin
        r_cnt <= '0;
        r_max <= '0;
        r_idx <= '0;
        r_sat <= 1'b0;
      end else if (w_beat && !abort) begin
        r_cnt <= r_cnt + 4'd1;
        r_max <= w_upd_max;
        r_idx <= w_upd_idx;
        r_sat <= w_upd_sat;
      end
      // Result registers only move on a completed frame, so an abort leaves the last report visible.
      if (w_last && !abort) begin
        r_res_max <= w_upd_max;
        r_res_idx <= w_upd_idx;
        r_res_sat <= w_upd_sat;
      end
    end
  end

  assign result_index = r_res_idx;
  assign result_max   = r_res_max;
  assign sat_seen     = r_res_sat;

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Bench for argmax_stream_ctrl: directed vector table, corner sequences and randomized frames vs a rank model.
module tb_argmax_stream_ctrl;
  localparam int N = 10;
  localparam logic [15:0] SENT = 16'h8000;

  logic        clk = 1'b0;
  logic        rst, start, abort, score_valid, result_ready;
  logic [15:0] score_data;
  logic        score_ready, result_valid, sat_seen, busy;
  logic [3:0]  result_index;
  logic [15:0] result_max;

  always #5 clk = ~clk;

  argmax_stream_ctrl #(.BIT(16), .N_CLASS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .score_valid(score_valid), .score_data(score_data), .score_ready(score_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_index(result_index), .result_max(result_max),
    .sat_seen(sat_seen), .busy(busy)
  );

  typedef struct packed {
    logic [N-1:0][15:0] sc;
    logic [3:0]         idx;
    logic [15:0]        mx;
    logic               sat;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] tmp [N];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  last_idx = '0;
  logic [15:0] last_mx = '0;
  logic        last_sat = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0][15:0] pk(input logic [15:0] a [N]);
    logic [N-1:0][15:0] r;
    for (int k = 0; k < N; k++) r[k] = a[k];
    return r;
  endfunction

  function automatic logic [N-1:0][15:0] fill(input logic [15:0] v);
    logic [N-1:0][15:0] r;
    for (int k = 0; k < N; k++) r[k] = v;
    return r;
  endfunction

  // Ranks: sentinel above everything, otherwise plain signed value; strict > keeps the earliest beat.
  task automatic model(input logic [N-1:0][15:0] sc, output logic [3:0] idx,
                       output logic [15:0] mx, output logic sat);
    int best, r, bk;
    best = 0; bk = 0; sat = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sc[k] == SENT) begin
        r = 1000000;
        sat = 1'b1;
      end else begin
        r = sc[k][15] ? -int'(sc[k][14:0]) : int'(sc[k][14:0]);
      end
      if (k == 0 || r > best) begin
        best = r;
        bk = k;
      end
    end
    idx = 4'(N - 1 - bk);
    mx  = sc[bk];
  endtask

  function automatic logic [15:0] rnd_score();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return SENT;
    if (sel <= 2) return 16'($urandom);
    return {1'($urandom_range(0, 1)), 15'($urandom_range(0, 12))};
  endfunction

  function automatic logic [N-1:0][15:0] rnd_frame();
    logic [N-1:0][15:0] r;
    for (int k = 0; k < N; k++) r[k] = rnd_score();
    return r;
  endfunction

  // Feeds one frame; gap is the percentage chance of a stall cycle before each beat.
  task automatic send_frame(input logic [N-1:0][15:0] sc, input bit do_start, input int gap);
    int st;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      st = 0;
      while (st < 4 && $urandom_range(0, 99) < gap) begin
        score_valid = 1'b0;
        score_data  = 16'($urandom);
        start       = 1'($urandom_range(0, 1));
        tick();
        st++;
      end
      start       = 1'b0;
      score_valid = 1'b1;
      score_data  = sc[k];
      chk("score_ready_in_collect", 32'(score_ready), 32'd1);
      if (k == N - 1) chk("result_valid_before_last", 32'(result_valid), 32'd0);
      tick();
    end
    score_valid = 1'b0;
    score_data  = 16'($urandom);
    chk("result_valid_latency", 32'(result_valid), 32'd1);
  endtask

  task automatic chk_result(input logic [3:0] idx, input logic [15:0] mx, input logic sat);
    chk("result_index", 32'(result_index), 32'(idx));
    chk("result_max", 32'(result_max), 32'(mx));
    chk("sat_seen", 32'(sat_seen), 32'(sat));
    last_idx = idx;
    last_mx  = mx;
    last_sat = sat;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("valid_drop_after_accept", 32'(result_valid), 32'd0);
    chk("idle_after_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N-1:0][15:0] fr;
    logic [3:0]  e_idx;
    logic [15:0] e_mx;
    logic        e_sat;

    tmp = '{16'h0005, 16'h0003, 16'h0010, 16'h0001, 16'h0002,
            16'h0000, 16'h0007, 16'h0004, 16'h0006, 16'h0008};
    vecs[0] = '{sc: pk(tmp), idx: 4'd7, mx: 16'h0010, sat: 1'b0};
    vecs[1] = '{sc: fill(16'h800A), idx: 4'd8, mx: 16'h8002, sat: 1'b0};
    vecs[1].sc[0] = 16'h8009; vecs[1].sc[1] = 16'h8002; vecs[1].sc[2] = 16'h8005;
    vecs[2] = '{sc: fill(16'h0001), idx: 4'd5, mx: 16'h8000, sat: 1'b1};
    vecs[2].sc[1] = 16'h0100; vecs[2].sc[4] = 16'h8000; vecs[2].sc[6] = 16'h7FFF;
    vecs[3] = '{sc: fill(16'h0001), idx: 4'd7, mx: 16'h0020, sat: 1'b0};
    vecs[3].sc[2] = 16'h0020; vecs[3].sc[5] = 16'h0020;
    tmp = '{16'h8005, 16'h8001, 16'h8003, 16'h0000, 16'h8007,
            16'h8002, 16'h8004, 16'h8006, 16'h8009, 16'h8008};
    vecs[4] = '{sc: pk(tmp), idx: 4'd6, mx: 16'h0000, sat: 1'b0};
    vecs[5] = '{sc: fill(16'h7FFF), idx: 4'd9, mx: 16'h8000, sat: 1'b1};
    vecs[5].sc[0] = 16'h8000;
    vecs[6] = '{sc: fill(16'h0001), idx: 4'd0, mx: 16'h7FFF, sat: 1'b0};
    vecs[6].sc[9] = 16'h7FFF;

    rst = 1'b1; start = 1'b1; abort = 1'b0; score_valid = 1'b1; result_ready = 1'b1;
    score_data = 16'h1234;
    tick(); tick();
    chk("rst_score_ready", 32'(score_ready), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_result_index", 32'(result_index), 32'd0);
    chk("rst_result_max", 32'(result_max), 32'd0);
    chk("rst_sat_seen", 32'(sat_seen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0; result_ready = 1'b0;

    // Scores offered while idle must be ignored.
    repeat (3) begin
      tick();
      chk("idle_score_ready", 32'(score_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    score_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].sc, 1'b1, (i % 2 == 1) ? 30 : 0);
      chk_result(vecs[i].idx, vecs[i].mx, vecs[i].sat);
      accept();
    end

    // Result held under consumer backpressure, then back-to-back frame on acceptance.
    fr = rnd_frame();
    model(fr, e_idx, e_mx, e_sat);
    send_frame(fr, 1'b1, 40);
    chk_result(e_idx, e_mx, e_sat);
    start = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_result_valid", 32'(result_valid), 32'd1);
      chk("hold_result_index", 32'(result_index), 32'(e_idx));
      chk("hold_result_max", 32'(result_max), 32'(e_mx));
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0; start = 1'b0;
    chk("b2b_score_ready", 32'(score_ready), 32'd1);
    chk("b2b_result_valid", 32'(result_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    fr = rnd_frame();
    model(fr, e_idx, e_mx, e_sat);
    send_frame(fr, 1'b0, 20);
    chk_result(e_idx, e_mx, e_sat);
    accept();

    // Abort after beat 4: no result, last report stays visible.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      score_valid = 1'b1;
      score_data  = 16'h7F00;
      tick();
    end
    score_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_score_ready", 32'(score_ready), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk("abort_keep_index", 32'(result_index), 32'(last_idx));
    chk("abort_keep_max", 32'(result_max), 32'(last_mx));
    repeat (3) begin
      tick();
      chk("abort_no_result", 32'(result_valid), 32'd0);
    end
    send_frame(vecs[0].sc, 1'b1, 25);
    chk_result(vecs[0].idx, vecs[0].mx, vecs[0].sat);

    // Abort in DONE outranks acceptance and start.
    abort = 1'b1; result_ready = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; result_ready = 1'b0; start = 1'b0;
    chk("done_abort_busy", 32'(busy), 32'd0);
    chk("done_abort_valid", 32'(result_valid), 32'd0);
    chk("done_abort_keep_max", 32'(result_max), 32'(last_mx));

    // Abort while idle is a no-op; then reset mid-frame.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_starts", 32'(score_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      score_valid = 1'b1;
      score_data  = 16'h0042;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; score_valid = 1'b0;
    chk("midrst_score_ready", 32'(score_ready), 32'd0);
    chk("midrst_result_valid", 32'(result_valid), 32'd0);
    chk("midrst_result_index", 32'(result_index), 32'd0);
    chk("midrst_result_max", 32'(result_max), 32'd0);
    chk("midrst_sat_seen", 32'(sat_seen), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    fr = rnd_frame();
    model(fr, e_idx, e_mx, e_sat);
    send_frame(fr, 1'b1, 20);
    chk_result(e_idx, e_mx, e_sat);
    for (int f = 0; f < 30; f++) begin
      fr = rnd_frame();
      model(fr, e_idx, e_mx, e_sat);
      if ($urandom_range(0, 1) == 1) begin
        result_ready = 1'b1; start = 1'b1;
        tick();
        result_ready = 1'b0; start = 1'b0;
        chk("rand_b2b_ready", 32'(score_ready), 32'd1);
        send_frame(fr, 1'b0, $urandom_range(0, 50));
      end else begin
        accept();
        send_frame(fr, 1'b1, $urandom_range(0, 50));
      end
      chk_result(e_idx, e_mx, e_sat);
    end
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
